// File: rtl/cpu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_RD   = 3'd1,
    S_LD_CAP  = 3'd2,
    S_ST_RD   = 3'd3,
    S_ST_MRG  = 3'd4,
    S_ST_WR   = 3'd5,
    S_RESP    = 3'd6
  } lsu_state_e;

  // True when the request cannot be performed as issued (reserved size or
  // an address that is not a multiple of the access size).
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Round an address down to the natural boundary of the access size.
  function automatic logic [31:0] force_align(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    case (size)
      SZ_HALF: a[0]   = 1'b0;
      SZ_BYTE: a      = addr;
      default: a[1:0] = 2'b00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extract/extend a load lane and merge a sub-word store into a read word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module lsu_lane_align
  import cpu_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [D_WIDTH-1:0] rd_word,
  input  logic [1:0]         byte_off,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  input  logic [D_WIDTH-1:0] st_data,
  output logic [D_WIDTH-1:0] ld_data,
  output logic [D_WIDTH-1:0] mrg_word
);

  logic [D_WIDTH-1:0] shifted;

  // Little-endian lane select with sign/zero extension, and lane replacement for RMW stores.
  always_comb begin
    shifted  = rd_word >> {byte_off, 3'b000};
    ld_data  = rd_word;
    mrg_word = rd_word;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        mrg_word[{byte_off, 3'b000} +: 8] = st_data[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        mrg_word[{byte_off[1], 4'b0000} +: 16] = st_data[15:0];
      end
      default: begin
        ld_data  = rd_word;
        mrg_word = st_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one CPU load/store at a time, sub-word stores via read-modify-write.
// Latency accept->resp_valid: error 1, word store 2, load 3, sub-word store 4 cycles.
// Backpressure: req_ready only in IDLE; LSU_MISALIGN_TRAP_EN selects trap vs force-align on misalignment.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [D_WIDTH-1:0] resp_rdata,
  output logic               mem_we,
  output logic [31:0]        mem_w_addr,
  output logic [D_WIDTH-1:0] mem_w_data,
  output logic               mem_re,
  output logic [31:0]        mem_r_addr,
  input  logic [D_WIDTH-1:0] mem_r_data
);

  lsu_state_e         state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [D_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic               acc_err;
  logic [1:0]         acc_size;
  logic [31:0]        acc_addr;
  logic [D_WIDTH-1:0] ld_data;
  logic [D_WIDTH-1:0] mrg_word;

  assign req_ready = (state_q == S_IDLE) && !rst;

  // Classify the incoming request: trap misalignment, or silently round it down.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    acc_err  = is_misaligned(req_size, req_addr[1:0]);
    acc_size = req_size;
    acc_addr = req_addr;
`else
    acc_err  = 1'b0;
    acc_size = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    acc_addr = force_align(acc_size, req_addr);
`endif
  end

  lsu_lane_align #(.D_WIDTH(D_WIDTH)) u_align (
    .rd_word     (mem_r_data),
    .byte_off    (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .mrg_word    (mrg_word)
  );

  // Next-state and next-output decode; strobes are computed one cycle ahead so they leave a flop.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d       = acc_addr;
          wdata_d      = req_wdata;
          size_d       = acc_size;
          uns_d        = req_unsigned;
          resp_err_d   = acc_err;
          resp_rdata_d = '0;
          if (acc_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end else if (!req_we) begin
            state_d  = S_LD_RD;
            mem_re_d = 1'b1;
          end else if (acc_size == SZ_WORD) begin
            state_d  = S_ST_WR;
            mem_we_d = 1'b1;
          end else begin
            state_d  = S_ST_RD;
            mem_re_d = 1'b1;
          end
        end
      end
      S_LD_RD:  state_d = S_LD_CAP;
      S_LD_CAP: begin
        resp_rdata_d = ld_data;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_ST_RD:  state_d = S_ST_MRG;
      S_ST_MRG: begin
        // The store data register now carries the full word to be written.
        wdata_d  = mrg_word;
        mem_we_d = 1'b1;
        state_d  = S_ST_WR;
      end
      S_ST_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM and request registers; reset aborts any sequence and drops all strobes at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_r_addr = {addr_q[31:2], 2'b00};
  assign mem_w_addr = {addr_q[31:2], 2'b00};
  assign mem_w_data = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random traffic against a word-array model.
// Latency: n/a.
// Backpressure: requests are only presented while req_ready is expected high.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_re(mem_re), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  // Data memory seen by the DUT: 16 words, registered read, preload port for the bench.
  logic [31:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_dat = 32'd0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (mem_we) mem[mem_w_addr[5:2]] <= mem_w_data;
    if (mem_re) mem_r_data <= mem[mem_r_addr[5:2]];
  end

  // Architectural view of memory, maintained from the instruction semantics alone.
  logic [31:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    return (w & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
  endfunction

  // One full transaction: present, accept, watch every cycle up to the response, check it all.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic [1:0]  szeff;
    logic [31:0] nb, ea, old, nw, exp_rd;
    logic        exp_err;
    int exp_lat, exp_re, exp_we, exp_we_cyc;
    int rv_cyc = 0, re_cnt = 0, re_cyc = 0, we_cnt = 0, we_cyc = 0, both = 0;
    logic [31:0] re_addr = 0, we_addr = 0, we_dat = 0, rd_s = 0;
    logic er_s = 1'b0;

    szeff   = (!TRAP && sz == 2'd3) ? 2'd2 : sz;
    nb      = 32'd1 << szeff;
    ea      = TRAP ? addr : (addr & ~(nb - 32'd1));
    exp_err = TRAP && (sz == 2'd3 || (addr & (nb - 32'd1)) != 0);
    old     = ref_mem[ea[5:2]];
    nw      = old;
    exp_rd  = 32'd0;
    exp_we_cyc = 0;
    if (exp_err) begin
      exp_lat = 1; exp_re = 0; exp_we = 0;
    end else if (!we) begin
      exp_lat = 3; exp_re = 1; exp_we = 0;
      exp_rd  = model_load(old, ea[1:0], szeff, uns);
    end else begin
      nw = model_store(old, ea[1:0], szeff, wd);
      ref_mem[ea[5:2]] = nw;
      exp_lat    = (szeff == 2'd2) ? 2 : 4;
      exp_re     = (szeff == 2'd2) ? 0 : 1;
      exp_we     = 1;
      exp_we_cyc = (szeff == 2'd2) ? 1 : 3;
    end

    chk("ready_before", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
    for (int k = 1; k <= 12; k++) begin
      if (mem_re) begin re_cnt++; if (re_cyc == 0) re_cyc = k; re_addr = mem_r_addr; end
      if (mem_we) begin we_cnt++; if (we_cyc == 0) we_cyc = k; we_addr = mem_w_addr; we_dat = mem_w_data; end
      if (mem_re && mem_we) both++;
      if (rv_cyc != 0) begin
        chk("resp_pulse", 32'(resp_valid), 0);
        chk("rdata_hold", resp_rdata, rd_s);
        chk("err_hold", 32'(resp_err), 32'(er_s));
        chk("ready_after", 32'(req_ready), 1);
        break;
      end
      if (resp_valid) begin rv_cyc = k; rd_s = resp_rdata; er_s = resp_err; end
      @(negedge clk);
    end
    chk("resp_lat", rv_cyc, exp_lat);
    chk("resp_err", 32'(er_s), 32'(exp_err));
    chk("resp_rdata", rd_s, exp_rd);
    chk("re_count", re_cnt, exp_re);
    chk("we_count", we_cnt, exp_we);
    chk("re_we_overlap", both, 0);
    if (exp_re != 0) begin
      chk("re_cycle", re_cyc, 1);
      chk("re_addr", re_addr, {ea[31:2], 2'b00});
    end
    if (exp_we != 0) begin
      chk("we_cycle", we_cyc, exp_we_cyc);
      chk("we_addr", we_addr, {ea[31:2], 2'b00});
      chk("we_data", we_dat, nw);
    end
    rd = rd_s;
    er = er_s;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          we_seen;

    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    // Preload memory while reset is held.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = 4'(i);
      pre_dat = (i == 4) ? 32'h8899AABB : $urandom;
      ref_mem[i] = pre_dat;
    end
    @(negedge clk);
    pre_we = 1'b0;

    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_r_addr", mem_r_addr, 0);
    chk("rst_mem_w_addr", mem_w_addr, 0);
    chk("rst_mem_w_data", mem_w_data, 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_out_of_rst", 32'(req_ready), 1);

    // Directed loads on the preloaded word 0x10.
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er); chk("LW_0x10", rd, 32'h8899AABB);
    run_op(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, rd, er); chk("LB_0x13", rd, 32'hFFFFFF88);
    run_op(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd, er); chk("LBU_0x13", rd, 32'h00000088);
    run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, rd, er); chk("LH_0x12", rd, 32'hFFFF8899);
    run_op(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, rd, er); chk("LHU_0x10", rd, 32'h0000AABB);
    run_op(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, rd, er);
    chk("LH_0x11_data", rd, TRAP ? 32'h0 : 32'hFFFFAABB);
    chk("LH_0x11_err", 32'(er), 32'(TRAP));

    // Reset during the merge phase of SB 0x11: the write must never happen.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h000000CC;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd", 32'(mem_re), 1);
    @(negedge clk);
    rst = 1'b1;
    we_seen = 0;
    @(negedge clk);
    if (mem_we) we_seen++;
    chk("abort_ready_in_rst", 32'(req_ready), 0);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      if (mem_we) we_seen++;
      @(negedge clk);
    end
    chk("abort_no_write", we_seen, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er); chk("abort_mem_kept", rd, 32'h8899AABB);

    // Sub-word store then word store/load back to back.
    run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000CC, rd, er);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er); chk("SB_result", rd, 32'h8899CCBB);
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, rd, er);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er); chk("SW_LW_b2b", rd, 32'h12345678);

    // Random traffic over the whole modelled space.
    for (int n = 0; n < 80; n++) begin
      run_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 63)), $urandom, rd, er);
    end

    // Final readback of every word.
    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'd0, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
